// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester.
package apb_pkg;

  // Default bus widths used by the requester and its command/response records.
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Transfer phases. SETUP lasts exactly one cycle. ACCESS lasts until pready or a timeout.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // One command as presented on the cmd_* stream (default-width configuration).
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // One response as returned on the rsp_* stream (default-width configuration).
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns one registered response per command. A wait-state
// timeout forces an error completion so that a dead slave cannot hold the bus.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream (no backpressure)
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB requester side
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // The counter only needs to reach TIMEOUT_CYCLES-1. It is kept at least 1 bit wide.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e        r_state, w_state_next;
  logic              r_psel, w_psel_next;
  logic              r_penable, w_penable_next;
  logic              r_pwrite, w_pwrite_next;
  logic [ADDR_W-1:0] r_paddr, w_paddr_next;
  logic [DATA_W-1:0] r_pwdata, w_pwdata_next;
  logic              r_rsp_valid, w_rsp_valid_next;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_next;
  logic              r_rsp_err, w_rsp_err_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;

  // Next-state and next-output decode for the transfer FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next     = r_state;
    w_psel_next      = r_psel;
    w_penable_next   = r_penable;
    w_pwrite_next    = r_pwrite;
    w_paddr_next     = r_paddr;
    w_pwdata_next    = r_pwdata;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    w_cnt_next       = r_cnt;

    case (r_state)
      IDLE: begin
        // cmd_ready is high in IDLE, so a valid command is accepted here.
        if (cmd_valid) begin
          w_state_next   = SETUP;
          w_psel_next    = 1'b1;
          w_penable_next = 1'b0;
          w_pwrite_next  = cmd_write;
          w_paddr_next   = cmd_addr;
          w_pwdata_next  = cmd_wdata;
          w_cnt_next     = '0;
        end
      end

      SETUP: begin
        w_state_next   = ACCESS;
        w_penable_next = 1'b1;
      end

      ACCESS: begin
        if (pready) begin
          // Normal completion. Writes return zero data.
          w_state_next     = IDLE;
          w_psel_next      = 1'b0;
          w_penable_next   = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = r_pwrite ? '0 : prdata;
          w_rsp_err_next   = pslverr;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          // The slave stalled for TIMEOUT_CYCLES access cycles. Abandon the transfer with an error.
          w_state_next     = IDLE;
          w_psel_next      = 1'b0;
          w_penable_next   = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next   = IDLE;
        w_psel_next    = 1'b0;
        w_penable_next = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
    if (!preset_n) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_psel      <= w_psel_next;
      r_penable   <= w_penable_next;
      r_pwrite    <= w_pwrite_next;
      r_paddr     <= w_paddr_next;
      r_pwdata    <= w_pwdata_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master with a small single-register APB slave model.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  int errors = 0;
  int checks = 0;

  // Slave model controls
  logic [DW-1:0] slave_reg;
  int            slv_wait;
  bit            slv_dead, slv_err, slv_load;
  int            acc_cnt;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Slave: one register at 0xA000. Other addresses read back a non-zero pattern.
  always @(posedge pclk) begin
    if (psel && penable) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
    if (slv_load) slave_reg <= 32'h1234_5678;
    else if (psel && penable && pready && pwrite && paddr == 32'hA000) slave_reg <= pwdata;
  end

  assign pready  = psel && penable && !slv_dead && (acc_cnt >= slv_wait);
  assign prdata  = (paddr == 32'hA000) ? slave_reg : 32'h5A5A_5A5A;
  assign pslverr = slv_err;

  // Issue one command from a negedge with cmd_ready high, then watch up to 40 cycles.
  // Cycle 0 is the accept cycle. Observations are taken at the negedge of each later cycle.
  task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int t_psel, output int t_pen, output int t_rsp,
                         output int n_pen, output int n_rsp, output logic [DW-1:0] rdata,
                         output logic err, output logic psel_at_rsp,
                         output logic hold_ok, output logic dir_ok);
    t_psel = -1; t_pen = -1; t_rsp = -1; n_pen = 0; n_rsp = 0;
    rdata = 'x; err = 1'bx; psel_at_rsp = 1'bx; hold_ok = 1'b1; dir_ok = 1'b1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge pclk); @(negedge pclk);
    // Scramble the command inputs so that any leak into the bus is visible.
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
    for (int c = 1; c <= 40; c++) begin
      if (psel && t_psel < 0) t_psel = c;
      if (penable && t_pen < 0) t_pen = c;
      if (penable) n_pen++;
      if (t_psel >= 0 && (paddr !== a || (w && pwdata !== d))) hold_ok = 1'b0;
      if (psel && pwrite !== w) dir_ok = 1'b0;
      if (rsp_valid) begin
        n_rsp++;
        if (t_rsp < 0) begin
          t_rsp = c; rdata = rsp_rdata; err = rsp_err; psel_at_rsp = psel;
        end
      end
      if (t_rsp >= 0 && c >= t_rsp + 2) break;
      @(posedge pclk); @(negedge pclk);
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0; slv_load = 1'b1; cmd_valid = 1'b1;
    cmd_write = 1'b1; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", {psel, penable, pwrite}); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin errors++; $display("FAIL rst_rsp: got %b want 00", {rsp_valid, rsp_err}); end
    checks++; if (paddr !== 32'h0 || pwdata !== 32'h0) begin errors++; $display("FAIL rst_bus: paddr=%h pwdata=%h want 0", paddr, pwdata); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    cmd_valid = 1'b0; slv_load = 1'b0; preset_n = 1'b1;
    @(posedge pclk); @(negedge pclk);
    checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL rst_release: cmd_ready=%b psel=%b want 1 0", cmd_ready, psel); end
  endtask

  task automatic test_write();
    int tp, te, tr, np, nr; logic [DW-1:0] rd; logic er, pr, ho, dk;
    slv_wait = 0;
    do_xfer(1'b1, 32'hA000, 32'hDEAD_BEEF, tp, te, tr, np, nr, rd, er, pr, ho, dk);
    checks++; if (tp !== 1 || te !== 2) begin errors++; $display("FAIL wr_phase: psel@%0d penable@%0d want 1 2", tp, te); end
    checks++; if (tr !== 3 || nr !== 1) begin errors++; $display("FAIL wr_rsp: at %0d count %0d want 3 1", tr, nr); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wr_rsp_data: err=%b rdata=%h want 0 0", er, rd); end
    checks++; if (pr !== 1'b0) begin errors++; $display("FAIL wr_psel_drop: got %b want 0", pr); end
    checks++; if (ho !== 1'b1 || dk !== 1'b1) begin errors++; $display("FAIL wr_hold: hold=%b dir=%b want 1 1", ho, dk); end
    checks++; if (slave_reg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_slave: got %h want deadbeef", slave_reg); end
  endtask

  task automatic test_read();
    int tp, te, tr, np, nr; logic [DW-1:0] rd; logic er, pr, ho, dk;
    slv_wait = 0;
    do_xfer(1'b0, 32'hA000, 32'h0, tp, te, tr, np, nr, rd, er, pr, ho, dk);
    checks++; if (tr !== 3 || nr !== 1) begin errors++; $display("FAIL rd_rsp: at %0d count %0d want 3 1", tr, nr); end
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL rd_data: rdata=%h err=%b want deadbeef 0", rd, er); end
    checks++; if (dk !== 1'b1) begin errors++; $display("FAIL rd_pwrite: dir_ok=%b want 1", dk); end
  endtask

  task automatic test_wait_states();
    int tp, te, tr, np, nr; logic [DW-1:0] rd; logic er, pr, ho, dk;
    slv_wait = 3;
    do_xfer(1'b0, 32'hA000, 32'h0, tp, te, tr, np, nr, rd, er, pr, ho, dk);
    checks++; if (np !== 4) begin errors++; $display("FAIL ws_penable_cycles: got %0d want 4", np); end
    checks++; if (tr !== 6 || nr !== 1) begin errors++; $display("FAIL ws_rsp: at %0d count %0d want 6 1", tr, nr); end
    checks++; if (ho !== 1'b1) begin errors++; $display("FAIL ws_paddr_stable: got %b want 1", ho); end
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL ws_data: rdata=%h err=%b want deadbeef 0", rd, er); end
    slv_wait = 0;
  endtask

  task automatic test_timeout();
    int tp, te, tr, np, nr; logic [DW-1:0] rd; logic er, pr, ho, dk;
    slv_dead = 1'b1;
    do_xfer(1'b0, 32'hB000, 32'h0, tp, te, tr, np, nr, rd, er, pr, ho, dk);
    checks++; if (np !== 16) begin errors++; $display("FAIL to_access_cycles: got %0d want 16", np); end
    checks++; if (tr !== 18 || nr !== 1) begin errors++; $display("FAIL to_rsp: at %0d count %0d want 18 1", tr, nr); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL to_data: err=%b rdata=%h want 1 0", er, rd); end
    checks++; if (pr !== 1'b0) begin errors++; $display("FAIL to_psel_drop: got %b want 0", pr); end
    slv_dead = 1'b0;
  endtask

  task automatic test_slverr();
    int tp, te, tr, np, nr; logic [DW-1:0] rd; logic er, pr, ho, dk;
    slv_wait = 1; slv_err = 1'b1;
    do_xfer(1'b0, 32'hA000, 32'h0, tp, te, tr, np, nr, rd, er, pr, ho, dk);
    checks++; if (tr !== 4) begin errors++; $display("FAIL se_rsp_cycle: got %0d want 4", tr); end
    checks++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL se_data: err=%b rdata=%h want 1 deadbeef", er, rd); end
    slv_wait = 0; slv_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] ptr, rtr; int acc; logic go;
    acc = 0; ptr = '0; rtr = '0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hA000; cmd_wdata = 32'h1;
    for (int c = 0; c < 12; c++) begin
      ptr[c] = psel; rtr[c] = rsp_valid;
      go = cmd_valid && cmd_ready;
      if (go) acc++;
      @(posedge pclk); @(negedge pclk);
      if (go) begin
        if (acc == 1) cmd_wdata = 32'h2;
        else          cmd_valid = 1'b0;
      end
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
    checks++; if (ptr !== 12'h036) begin errors++; $display("FAIL b2b_psel_trace: got %h want 036", ptr); end
    checks++; if (rtr !== 12'h048) begin errors++; $display("FAIL b2b_rsp_trace: got %h want 048", rtr); end
    checks++; if (slave_reg !== 32'h2) begin errors++; $display("FAIL b2b_slave: got %h want 2", slave_reg); end
  endtask

  task automatic test_reset_mid();
    int tp, te, tr, np, nr, nsp; logic [DW-1:0] rd; logic er, pr, ho, dk;
    slv_dead = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hA000; cmd_wdata = 32'h0;
    @(posedge pclk); @(negedge pclk);
    cmd_valid = 1'b0;
    @(posedge pclk); @(negedge pclk);
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rm_in_access: penable=%b want 1", penable); end
    preset_n = 1'b0;
    @(posedge pclk); @(negedge pclk);
    checks++; if ({psel, penable, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rm_drop: got %b want 000", {psel, penable, rsp_valid}); end
    preset_n = 1'b1;
    nsp = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) nsp++;
      @(posedge pclk); @(negedge pclk);
    end
    checks++; if (nsp !== 0) begin errors++; $display("FAIL rm_no_rsp: got %0d pulses want 0", nsp); end
    slv_dead = 1'b0;
    do_xfer(1'b1, 32'hA000, 32'hCAFE_F00D, tp, te, tr, np, nr, rd, er, pr, ho, dk);
    checks++; if (tr !== 3 || er !== 1'b0) begin errors++; $display("FAIL rm_next_write: at %0d err=%b want 3 0", tr, er); end
    checks++; if (slave_reg !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_slave: got %h want cafef00d", slave_reg); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    slv_wait = 0; slv_dead = 1'b0; slv_err = 1'b0; slv_load = 1'b0;
    preset_n = 1'b0;
    @(negedge pclk);
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the whole run in case the DUT wedges.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
